// File: rtl/sdram_rw_arbiter.sv
// Sequencer/arbiter for the shared SDRAM Avalon-MM master: streams a sample window
// out as reads and writes processed samples back in place, with capped in-flight reads.
module sdram_rw_arbiter #(
   parameter int unsigned ADDR_W          = 24,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned STRIDE          = 4,
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter int unsigned STARVE_LIMIT    = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_count,
   output logic              busy,
   output logic              done,
   input  logic              rd_credit_ok,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [ADDR_W-1:0] av_address,
   output logic              av_read,
   output logic              av_write,
   output logic [DATA_W-1:0] av_writedata,
   input  logic [DATA_W-1:0] av_readdata,
   input  logic              av_readdatavalid,
   input  logic              av_waitrequest,
   output logic [7:0]        outstanding,
   output logic              err_spurious
);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

   typedef enum logic [1:0] {IDLE, ARB, READ, WRITE} state_e;

   state_e            state_q, state_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_left_q, rd_left_d, wr_left_q, wr_left_d;
   logic [ADDR_W-1:0] reads_issued_q, reads_issued_d, writes_done_q, writes_done_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [7:0]        outstanding_q, outstanding_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d, av_writedata_q, av_writedata_d;
   logic              rd_valid_q, rd_valid_d, wr_ready_q, wr_ready_d;
   logic [ADDR_W-1:0] av_address_q, av_address_d;
   logic              av_read_q, av_read_d, av_write_q, av_write_d;
   logic              err_q, err_d;
   logic              rd_elig, wr_elig, rd_accept, rd_return;

   always_comb begin
      state_d        = state_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      rd_addr_d      = rd_addr_q;
      wr_addr_d      = wr_addr_q;
      rd_left_d      = rd_left_q;
      wr_left_d      = wr_left_q;
      reads_issued_d = reads_issued_q;
      writes_done_d  = writes_done_q;
      starve_d       = starve_q;
      outstanding_d  = outstanding_q;
      rd_data_d      = rd_data_q;
      rd_valid_d     = 1'b0;
      wr_ready_d     = 1'b0;
      av_address_d   = av_address_q;
      av_read_d      = av_read_q;
      av_write_d     = av_write_q;
      av_writedata_d = av_writedata_q;
      err_d          = err_q;

      rd_elig   = (rd_left_q != '0) && (outstanding_q < 8'(MAX_OUTSTANDING)) && rd_credit_ok;
      // Writes trail accepted reads so a sample is never overwritten before it is fetched
      wr_elig   = (wr_left_q != '0) && wr_valid && (writes_done_q < reads_issued_q);
      rd_accept = (state_q == READ) && !av_waitrequest;
      rd_return = av_readdatavalid && (outstanding_q != '0);

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_count != '0) begin
                  rd_addr_d      = cfg_base;
                  wr_addr_d      = cfg_base;
                  rd_left_d      = cfg_count;
                  wr_left_d      = cfg_count;
                  reads_issued_d = '0;
                  writes_done_d  = '0;
                  starve_d       = '0;
                  busy_d         = 1'b1;
                  state_d        = ARB;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ARB: begin
            if ((rd_left_q == '0) && (wr_left_q == '0) && (outstanding_q == '0)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (wr_elig && (!rd_elig || (starve_q >= SW'(STARVE_LIMIT)))) begin
               av_writedata_d = wr_data;
               wr_ready_d     = 1'b1;
               av_write_d     = 1'b1;
               av_address_d   = wr_addr_q;
               starve_d       = '0;
               state_d        = WRITE;
            end else if (rd_elig) begin
               av_read_d    = 1'b1;
               av_address_d = rd_addr_q;
               if (wr_elig) starve_d = starve_q + SW'(1);
               state_d      = READ;
            end
         end
         READ: begin
            if (!av_waitrequest) begin
               rd_addr_d      = rd_addr_q + ADDR_W'(STRIDE);
               rd_left_d      = rd_left_q - ADDR_W'(1);
               reads_issued_d = reads_issued_q + ADDR_W'(1);
               av_read_d      = 1'b0;
               state_d        = ARB;
            end
         end
         WRITE: begin
            if (!av_waitrequest) begin
               wr_addr_d     = wr_addr_q + ADDR_W'(STRIDE);
               wr_left_d     = wr_left_q - ADDR_W'(1);
               writes_done_d = writes_done_q + ADDR_W'(1);
               av_write_d    = 1'b0;
               state_d       = ARB;
            end
         end
         default: state_d = IDLE;
      endcase

      case ({rd_accept, rd_return})
         2'b10:   outstanding_d = outstanding_q + 8'd1;
         2'b01:   outstanding_d = outstanding_q - 8'd1;
         default: outstanding_d = outstanding_q;
      endcase

      if (av_readdatavalid) begin
         if (outstanding_q != '0) begin
            rd_data_d  = av_readdata;
            rd_valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         rd_addr_q      <= '0;
         wr_addr_q      <= '0;
         rd_left_q      <= '0;
         wr_left_q      <= '0;
         reads_issued_q <= '0;
         writes_done_q  <= '0;
         starve_q       <= '0;
         outstanding_q  <= '0;
         rd_data_q      <= '0;
         rd_valid_q     <= 1'b0;
         wr_ready_q     <= 1'b0;
         av_address_q   <= '0;
         av_read_q      <= 1'b0;
         av_write_q     <= 1'b0;
         av_writedata_q <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         rd_addr_q      <= rd_addr_d;
         wr_addr_q      <= wr_addr_d;
         rd_left_q      <= rd_left_d;
         wr_left_q      <= wr_left_d;
         reads_issued_q <= reads_issued_d;
         writes_done_q  <= writes_done_d;
         starve_q       <= starve_d;
         outstanding_q  <= outstanding_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
         wr_ready_q     <= wr_ready_d;
         av_address_q   <= av_address_d;
         av_read_q      <= av_read_d;
         av_write_q     <= av_write_d;
         av_writedata_q <= av_writedata_d;
         err_q          <= err_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign wr_ready     = wr_ready_q;
   assign av_address   = av_address_q;
   assign av_read      = av_read_q;
   assign av_write     = av_write_q;
   assign av_writedata = av_writedata_q;
   assign outstanding  = outstanding_q;
   assign err_spurious = err_q;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Randomized bench for sdram_rw_arbiter: an Avalon slave and write source drive the DUT,
// a transaction-level model predicts addresses, data, credits and starvation gaps.
module tb_sdram_rw_arbiter;
   localparam int unsigned AW = 24;
   localparam int unsigned DW = 32;
   localparam int unsigned ST = 4;
   localparam int unsigned MO = 16;
   localparam int unsigned SL = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cfg_start = 1'b0;
   logic [AW-1:0] cfg_base = '0;
   logic [AW-1:0] cfg_count = '0;
   logic          busy, done, rd_valid, wr_ready, av_read, av_write, err_spurious;
   logic          rd_credit_ok = 1'b0;
   logic [DW-1:0] rd_data, av_writedata;
   logic [DW-1:0] wr_data = '0;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] av_address;
   logic [DW-1:0] av_readdata = '0;
   logic          av_readdatavalid = 1'b0;
   logic          av_waitrequest = 1'b0;
   logic [7:0]    outstanding;

   always #5 clk = ~clk;

   sdram_rw_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STRIDE(ST), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_base(cfg_base),
      .cfg_count(cfg_count), .busy(busy), .done(done), .rd_credit_ok(rd_credit_ok),
      .rd_data(rd_data), .rd_valid(rd_valid), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .av_address(av_address), .av_read(av_read), .av_write(av_write),
      .av_writedata(av_writedata), .av_readdata(av_readdata),
      .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest),
      .outstanding(outstanding), .err_spurious(err_spurious)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Environment knobs
   bit env_en = 0;
   int wait_pct = 0, lat_min = 3, lat_max = 3, credit_pct = 100, wr_pct = 100;
   int hold_wr = 0;
   bit ret_en = 1;
   int ret_budget = 0;
   bit wr_hold_mode = 0;
   bit force_spur = 0;
   bit gap_chk = 0;

   // Reference model state
   logic [AW-1:0] m_base;
   int            m_cnt, nr, nw, m_out, gap, n_gap, wr_avail, cyc;
   int            n_done, n_wrdy, done0, wrdy0;
   bit            exp_rdv, exp_err, held;
   logic [DW-1:0] exp_rdd;
   logic [63:0]   hold_snap;
   logic [DW-1:0] ret_q[$];
   int            due_q[$];
   logic [DW-1:0] wexp_q[$];

   function automatic logic [AW-1:0] sample_addr(input logic [AW-1:0] b, input int i);
      return b + AW'(i * ST);
   endfunction

   task automatic env_step();
      logic          cmd, wt, rdv, inc;
      logic [DW-1:0] rdd, exp_wd;
      // Outputs now reflect the edge that just consumed the inputs driven last negedge
      chk("rd_valid", rd_valid, exp_rdv);
      if (exp_rdv) begin
         chk("rd_data", rd_data, exp_rdd);
         wr_avail++;
      end
      chk("err_spurious", err_spurious, exp_err);
      chk("outstanding", outstanding, m_out);
      chk("rw_exclusive", av_read & av_write, 0);
      if (held) chk("cmd_hold", {av_read, av_write, av_address, av_writedata}, hold_snap);
      if (wr_ready) begin
         chk("wr_ready_with_write", av_write, 1);
         wexp_q.push_back(wr_data);
         n_wrdy++;
         if (wr_avail > 0) wr_avail--;
         wr_data = $urandom;
      end
      if (done) begin
         n_done++;
         chk("busy_clear_with_done", busy, 0);
      end

      cmd = av_read | av_write;
      inc = 0;
      if (av_write && hold_wr > 0) begin
         wt = 1;
         hold_wr--;
      end else begin
         wt = ($urandom_range(99) < wait_pct);
      end
      held = cmd && wt;
      hold_snap = {av_read, av_write, av_address, av_writedata};
      if (cmd && !wt) begin
         if (av_read) begin
            chk("rd_addr", av_address, sample_addr(m_base, nr));
            ret_q.push_back($urandom);
            due_q.push_back(cyc + $urandom_range(lat_max, lat_min));
            nr++;
            gap++;
            inc = 1;
         end else begin
            chk("wr_addr", av_address, sample_addr(m_base, nw));
            chk("wr_after_rd", nw < nr, 1);
            exp_wd = 'x;
            if (wexp_q.size() > 0) exp_wd = wexp_q.pop_front();
            chk("wr_data", av_writedata, exp_wd);
            if (gap_chk && nr < m_cnt) begin
               chk("starve_gap", gap, (nw == 0) ? SL + 1 : SL);
               n_gap++;
            end
            gap = 0;
            nw++;
         end
      end

      rdv = 0;
      rdd = '0;
      if (force_spur) begin
         rdv = 1;
         rdd = $urandom;
         force_spur = 0;
      end else if ((ret_en || ret_budget > 0) && due_q.size() > 0 && due_q[0] <= cyc) begin
         void'(due_q.pop_front());
         rdd = ret_q.pop_front();
         rdv = 1;
         if (!ret_en) ret_budget--;
      end
      exp_rdv = rdv && (m_out > 0);
      exp_rdd = rdd;
      if (rdv && m_out == 0) exp_err = 1;
      m_out = m_out + (inc ? 1 : 0) - (exp_rdv ? 1 : 0);

      av_waitrequest   = wt;
      av_readdatavalid = rdv;
      av_readdata      = rdd;
      wr_valid         = wr_hold_mode || (wr_avail > 0 && $urandom_range(99) < wr_pct);
      rd_credit_ok     = ($urandom_range(99) < credit_pct);
      cyc++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (env_en) env_step();
      end
   end

   task automatic clear_model();
      m_out = 0; exp_rdv = 0; exp_err = 0; held = 0; wr_avail = 0; hold_wr = 0;
      ret_q.delete(); due_q.delete(); wexp_q.delete();
      av_waitrequest = 0; av_readdatavalid = 0; av_readdata = '0; wr_valid = 0;
   endtask

   task automatic set_mode(input int wp, input int lmin, input int lmax, input int cp, input int wrp);
      wait_pct = wp; lat_min = lmin; lat_max = lmax; credit_pct = cp; wr_pct = wrp;
   endtask

   task automatic start_job(input logic [AW-1:0] b, input int c);
      @(posedge clk);
      #2;
      m_base = b; m_cnt = c; nr = 0; nw = 0; gap = 0; wr_avail = 0;
      done0 = n_done; wrdy0 = n_wrdy;
      cfg_base = b; cfg_count = AW'(c); cfg_start = 1;
      @(posedge clk);
      #2;
      cfg_start = 0;
   endtask

   task automatic finish_job(input string tag, input int c, input int budget);
      int k = 0;
      while (n_done == done0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_in_time"}, k < budget, 1);
      repeat (3) @(negedge clk);
      chk({tag, "_done_once"}, n_done - done0, 1);
      chk({tag, "_reads"}, nr, c);
      chk({tag, "_writes"}, nw, c);
      chk({tag, "_wr_ready_count"}, n_wrdy - wrdy0, c);
      chk({tag, "_outstanding_end"}, outstanding, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_wdata_drained"}, wexp_q.size(), 0);
   endtask

   initial begin
      int nr_prev;
      cyc = 0; n_done = 0; n_wrdy = 0; n_gap = 0;
      m_base = '0; m_cnt = 0; nr = 0; nw = 0; gap = 0;
      clear_model();
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_av_read", av_read, 0);
      chk("rst_av_write", av_write, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_spurious, 0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1;
      env_en = 1;

      // Basic job with start-to-command latency check
      set_mode(0, 3, 3, 100, 100);
      start_job(24'h100, 4);
      @(negedge clk);
      chk("start_busy", busy, 1);
      chk("start_cmd_n1", av_read, 0);
      @(negedge clk);
      chk("start_cmd_n2", av_read, 1);
      chk("start_addr", av_address, 24'h100);
      finish_job("basic", 4, 500);

      // Credit cap: no returns until released
      ret_en = 0; ret_budget = 0;
      start_job(24'h4000, 32);
      repeat (80) @(negedge clk);
      chk("credit_reads", nr, MO);
      chk("credit_outstanding", outstanding, MO);
      chk("credit_rd_low", av_read, 0);
      ret_budget = 1;
      repeat (12) @(negedge clk);
      chk("credit_one_more", nr, MO + 1);
      chk("credit_rd_low2", av_read, 0);
      ret_en = 1;
      finish_job("credit", 32, 3000);

      // Starvation: writes always offered, reads always eligible
      wr_hold_mode = 1; gap_chk = 1; n_gap = 0;
      start_job(24'h8000, 40);
      finish_job("starve", 40, 3000);
      chk("starve_gap_checks", n_gap, 4);
      wr_hold_mode = 0; gap_chk = 0;

      // Waitrequest held for 5 cycles on the first write
      hold_wr = 5;
      start_job(24'h200, 3);
      finish_job("wrhold", 3, 500);
      chk("wrhold_used", hold_wr, 0);

      // Address wrap
      set_mode(25, 1, 5, 80, 70);
      start_job(24'hFFFFF8, 6);
      finish_job("wrap", 6, 1000);

      // Zero-length window
      set_mode(0, 3, 3, 100, 100);
      nr_prev = nr; done0 = n_done;
      @(posedge clk);
      #2;
      cfg_base = 24'h300; cfg_count = '0; cfg_start = 1;
      @(posedge clk);
      #2;
      cfg_start = 0;
      @(negedge clk);
      chk("cnt0_done", done, 1);
      chk("cnt0_busy", busy, 0);
      repeat (6) @(negedge clk);
      chk("cnt0_no_read", nr, nr_prev);
      chk("cnt0_done_once", n_done - done0, 1);

      // Spurious return while idle
      force_spur = 1;
      repeat (3) @(negedge clk);
      chk("spur_err", err_spurious, 1);
      chk("spur_outstanding", outstanding, 0);

      // Randomized jobs
      for (int j = 0; j < 6; j++) begin
         set_mode($urandom_range(40), 1, $urandom_range(6, 1), $urandom_range(100, 50),
                  $urandom_range(100, 30));
         start_job(AW'($urandom), $urandom_range(40, 1));
         finish_job("rand", m_cnt, 3000);
      end

      // Reset mid-job
      set_mode(10, 2, 6, 100, 60);
      start_job(24'h1230, 30);
      repeat (25) @(negedge clk);
      chk("midjob_busy", busy, 1);
      @(posedge clk);
      #3 reset_n = 0;
      env_en = 0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_av_read", av_read, 0);
      chk("async_av_write", av_write, 0);
      chk("async_av_address", av_address, 0);
      chk("async_av_writedata", av_writedata, 0);
      chk("async_wr_ready", wr_ready, 0);
      chk("async_rd_valid", rd_valid, 0);
      chk("async_rd_data", rd_data, 0);
      chk("async_outstanding", outstanding, 0);
      chk("async_err", err_spurious, 0);
      clear_model();
      repeat (2) @(posedge clk);
      #3 reset_n = 1;
      env_en = 1;
      start_job(24'h5000, 5);
      finish_job("post_reset", 5, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
